mc_ctrl_fsm: RTL and testbench

//  Parametrised multi-cycle MIPS control FSM; successor to the fixed 9-state controller.

---
 rtl/mc_ctrl_fsm_pkg.sv | 108 ++++++++++
 rtl/mc_ctrl_fsm_if.sv | 54 +++++
 rtl/mc_ctrl_fsm_irq_prienc.sv | 18 +
 rtl/mc_ctrl_fsm.sv | 182 ++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcodes, select codes, exception codes.
// The MC_CTRL_ILLEGAL_TRAP_EN build option uses EXC_RI from here.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IF      = 4'd0,
        S_ID      = 4'd1,
        S_EXE_MEM = 4'd2,
        S_MEM     = 4'd3,
        S_WB_MEM  = 4'd4,
        S_EXE_BR  = 4'd5,
        S_EXE_R   = 4'd6,
        S_WB_R    = 4'd7,
        S_INT     = 4'd8
    } state_t;

    typedef enum logic [4:0] {
        I_ADDU, I_SUBU, I_SLT, I_JR, I_JALR, I_ADDI, I_ADDIU, I_ORI, I_LUI,
        I_LW, I_SW, I_LB, I_SB, I_BEQ, I_BNE, I_J, I_JAL, I_MFC0, I_MTC0, I_ERET, I_BAD
    } instr_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_ORI = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f, OP_COP0 = 6'h10, OP_LB   = 6'h20, OP_LW  = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28, OP_SW   = 6'h2b;
    localparam logic [5:0] FN_JR    = 6'h08, FN_JALR = 6'h09, FN_ERET = 6'h18;
    localparam logic [5:0] FN_ADDU  = 6'h21, FN_SUBU = 6'h23, FN_SLT  = 6'h2a;
    localparam logic [4:0] RS_MF    = 5'h00, RS_MT   = 5'h04, RS_CO   = 5'h10;

    localparam logic [2:0] NPC_PC4 = 3'd0, NPC_BR = 3'd1, NPC_JTGT = 3'd2;
    localparam logic [2:0] NPC_GPR = 3'd3, NPC_EPC = 3'd4, NPC_EXC = 3'd5;
    localparam logic [1:0] DST_RT = 2'd0, DST_RD = 2'd1, DST_RA = 2'd2;
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_OR = 3'd2, ALU_SLT = 3'd3;
    localparam logic [1:0] EXT_ZERO = 2'd0, EXT_SIGN = 2'd1, EXT_LUI = 2'd2;
    localparam logic [2:0] M2R_ALU = 3'd0, M2R_DM = 3'd1, M2R_PC4 = 3'd2;
    localparam logic [2:0] M2R_CP0 = 3'd3, M2R_BRIDGE = 3'd4;
    localparam logic [4:0] EXC_INT = 5'd0, EXC_RI = 5'd10;

    typedef struct packed {
        logic       pc_wr;
        logic [2:0] npc_sel;
        logic [1:0] reg_dst;
        logic       alu_src;
        logic [2:0] alu_ctr;
        logic [1:0] ext_op;
        logic [2:0] mem_to_reg;
        logic       reg_wr;
        logic       mem_req;
        logic       mem_we;
        logic       cp0_wr;
        logic       mem_byte;
        logic       exl_set;
        logic       exl_clr;
    } ctrl_t;

    function automatic instr_t decode(input logic [5:0] op, input logic [5:0] funct,
                                      input logic [4:0] rs);
        instr_t ins;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: ins = I_ADDU;
                    FN_SUBU: ins = I_SUBU;
                    FN_SLT:  ins = I_SLT;
                    FN_JR:   ins = I_JR;
                    FN_JALR: ins = I_JALR;
                    default: ins = I_BAD;
                endcase
            end
            OP_COP0: begin
                if (rs == RS_MF) ins = I_MFC0;
                else if (rs == RS_MT) ins = I_MTC0;
                else if (rs == RS_CO && funct == FN_ERET) ins = I_ERET;
                else ins = I_BAD;
            end
            OP_ADDI:  ins = I_ADDI;
            OP_ADDIU: ins = I_ADDIU;
            OP_ORI:   ins = I_ORI;
            OP_LUI:   ins = I_LUI;
            OP_LW:    ins = I_LW;
            OP_SW:    ins = I_SW;
            OP_LB:    ins = I_LB;
            OP_SB:    ins = I_SB;
            OP_BEQ:   ins = I_BEQ;
            OP_BNE:   ins = I_BNE;
            OP_J:     ins = I_J;
            OP_JAL:   ins = I_JAL;
            default:  ins = I_BAD;
        endcase
        return ins;
    endfunction

    // ALU operand/operation setup shared by the execute and write-back steps of ALU instructions.
    function automatic ctrl_t alu_ctrl(input instr_t ins);
        ctrl_t c;
        c = '0;
        case (ins)
            I_SUBU:         c.alu_ctr = ALU_SUB;
            I_SLT:          c.alu_ctr = ALU_SLT;
            I_ADDI, I_ADDIU: begin c.alu_src = 1'b1; c.ext_op = EXT_SIGN; end
            I_ORI:          begin c.alu_src = 1'b1; c.alu_ctr = ALU_OR; c.ext_op = EXT_ZERO; end
            I_LUI:          begin c.alu_src = 1'b1; c.ext_op = EXT_LUI; end
            default:        c.alu_ctr = ALU_ADD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Decoder/datapath <-> controller bundle; master = controller side, slave = datapath side.
// exc_code exists only when MC_CTRL_ILLEGAL_TRAP_EN is defined.
interface mc_ctrl_fsm_if #(
    parameter int IRQ_W    = 6,
    parameter int IRQ_ID_W = 3
);
    logic [5:0]          op;
    logic [5:0]          funct;
    logic [4:0]          rs;
    logic [31:0]         mem_addr;
    logic                mem_ack;
    logic                zero;
    logic [IRQ_W-1:0]    irq;
    logic [IRQ_W-1:0]    irq_mask;
    logic                ie;
    logic                exl;
    logic                pc_wr;
    logic [2:0]          npc_sel;
    logic [1:0]          reg_dst;
    logic                alu_src;
    logic [2:0]          alu_ctr;
    logic [1:0]          ext_op;
    logic [2:0]          mem_to_reg;
    logic                reg_wr;
    logic                mem_req;
    logic                mem_we;
    logic                cp0_wr;
    logic                mem_byte;
    logic                exl_set;
    logic                exl_clr;
    logic [IRQ_ID_W-1:0] irq_id;
    logic [3:0]          state;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic [4:0]          exc_code;
`endif

    modport master (
        input  op, funct, rs, mem_addr, mem_ack, zero, irq, irq_mask, ie, exl,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        output exc_code,
`endif
        output pc_wr, npc_sel, reg_dst, alu_src, alu_ctr, ext_op, mem_to_reg, reg_wr,
               mem_req, mem_we, cp0_wr, mem_byte, exl_set, exl_clr, irq_id, state
    );

    modport slave (
        output op, funct, rs, mem_addr, mem_ack, zero, irq, irq_mask, ie, exl,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        input  exc_code,
`endif
        input  pc_wr, npc_sel, reg_dst, alu_src, alu_ctr, ext_op, mem_to_reg, reg_wr,
               mem_req, mem_we, cp0_wr, mem_byte, exl_set, exl_clr, irq_id, state
    );
endinterface

// File: rtl/mc_ctrl_fsm_irq_prienc.sv
// Masked interrupt vector -> any-pending flag and lowest-index pending line id.
module mc_irq_prienc #(
    parameter int IRQ_W    = 6,
    parameter int IRQ_ID_W = 3
) (
    input  logic [IRQ_W-1:0]    pend,
    output logic                any,
    output logic [IRQ_ID_W-1:0] id
);
    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        id  = '0;
        any = |pend;
        for (int i = IRQ_W - 1; i >= 0; i--) begin
            id = pend[i] ? IRQ_ID_W'(i) : id;
        end
    end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM with memory wait states, bne, masked IRQs and exception vectoring.
// Define MC_CTRL_ILLEGAL_TRAP_EN to trap unknown instructions (RI) instead of executing them as NOP.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int          IRQ_W     = 6,
    parameter int          IRQ_ID_W  = 3,
    parameter logic [23:0] BRIDGE_HI = 24'h7f
) (
    input logic           clk,
    input logic           rst,
    mc_ctrl_fsm_if.master bus
);
    state_t              state_r;
    state_t              next_s;
    instr_t              instr_s;
    ctrl_t               ctrl_s;
    ctrl_t               ctrl_out_s;
    logic [IRQ_W-1:0]    pend_s;
    logic                irq_any_s;
    logic                take_s;
    logic                is_store_s;
    logic [IRQ_ID_W-1:0] irq_id_s;
    logic [IRQ_ID_W-1:0] irq_id_sel_s;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic [4:0]          exc_code_s;
`endif

    assign instr_s    = decode(bus.op, bus.funct, bus.rs);
    assign is_store_s = (instr_s == I_SW) || (instr_s == I_SB);
    assign pend_s     = bus.irq & bus.irq_mask;
    assign take_s     = irq_any_s & bus.ie & ~bus.exl;

    mc_irq_prienc #(.IRQ_W(IRQ_W), .IRQ_ID_W(IRQ_ID_W)) u_prienc (
        .pend (pend_s),
        .any  (irq_any_s),
        .id   (irq_id_s)
    );

    // State register; the only storage in the controller.
    always_ff @(posedge clk) begin
        if (rst) state_r <= S_IF;
        else     state_r <= next_s;
    end

    // Next-state and control decode from current state plus the live IR/status inputs.
    always_comb begin
        next_s       = state_r;
        ctrl_s       = '0;
        irq_id_sel_s = '0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        exc_code_s   = EXC_INT;
`endif
        case (state_r)
            S_IF: begin
                ctrl_s.pc_wr   = 1'b1;
                ctrl_s.npc_sel = NPC_PC4;
                next_s         = S_ID;
            end
            S_ID: begin
                case (instr_s)
                    I_J:    begin ctrl_s.pc_wr = 1'b1; ctrl_s.npc_sel = NPC_JTGT; next_s = S_INT; end
                    I_JR:   begin ctrl_s.pc_wr = 1'b1; ctrl_s.npc_sel = NPC_GPR;  next_s = S_INT; end
                    I_JAL: begin
                        ctrl_s.pc_wr      = 1'b1;
                        ctrl_s.npc_sel    = NPC_JTGT;
                        ctrl_s.reg_wr     = 1'b1;
                        ctrl_s.reg_dst    = DST_RA;
                        ctrl_s.mem_to_reg = M2R_PC4;
                        next_s            = S_INT;
                    end
                    I_JALR: begin
                        ctrl_s.pc_wr      = 1'b1;
                        ctrl_s.npc_sel    = NPC_GPR;
                        ctrl_s.reg_wr     = 1'b1;
                        ctrl_s.reg_dst    = DST_RD;
                        ctrl_s.mem_to_reg = M2R_PC4;
                        next_s            = S_INT;
                    end
                    I_ERET: begin
                        ctrl_s.pc_wr   = 1'b1;
                        ctrl_s.npc_sel = NPC_EPC;
                        ctrl_s.exl_clr = 1'b1;
                        next_s         = S_INT;
                    end
                    I_LW, I_SW, I_LB, I_SB: next_s = S_EXE_MEM;
                    I_BEQ, I_BNE:           next_s = S_EXE_BR;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    I_BAD: begin
                        ctrl_s.pc_wr   = 1'b1;
                        ctrl_s.npc_sel = NPC_EXC;
                        ctrl_s.exl_set = 1'b1;
                        exc_code_s     = EXC_RI;
                        next_s         = S_INT;
                    end
`endif
                    default: next_s = S_EXE_R;
                endcase
            end
            S_EXE_MEM: begin
                ctrl_s.alu_ctr = ALU_ADD;
                ctrl_s.alu_src = 1'b1;
                ctrl_s.ext_op  = EXT_SIGN;
                next_s         = S_MEM;
            end
            S_MEM: begin
                // Request and direction stay constant for the whole wait period.
                ctrl_s.mem_req  = 1'b1;
                ctrl_s.mem_we   = is_store_s;
                ctrl_s.mem_byte = (instr_s == I_LB) || (instr_s == I_SB);
                if (bus.mem_ack) next_s = is_store_s ? S_INT : S_WB_MEM;
                else             next_s = S_MEM;
            end
            S_WB_MEM: begin
                ctrl_s.reg_wr     = 1'b1;
                ctrl_s.reg_dst    = DST_RT;
                ctrl_s.mem_to_reg = (bus.mem_addr[31:8] == BRIDGE_HI) ? M2R_BRIDGE : M2R_DM;
                next_s            = S_INT;
            end
            S_EXE_BR: begin
                ctrl_s.alu_ctr = ALU_SUB;
                if ((instr_s == I_BEQ && bus.zero) || (instr_s == I_BNE && !bus.zero)) begin
                    ctrl_s.pc_wr   = 1'b1;
                    ctrl_s.npc_sel = NPC_BR;
                end else begin
                    ctrl_s.pc_wr   = 1'b0;
                end
                next_s = S_INT;
            end
            S_EXE_R: begin
                ctrl_s = alu_ctrl(instr_s);
                next_s = S_WB_R;
            end
            S_WB_R: begin
                ctrl_s = alu_ctrl(instr_s);
                case (instr_s)
                    I_ADDU, I_SUBU, I_SLT: begin ctrl_s.reg_wr = 1'b1; ctrl_s.reg_dst = DST_RD; end
                    I_ADDI, I_ADDIU, I_ORI, I_LUI: ctrl_s.reg_wr = 1'b1;
                    I_MFC0: begin ctrl_s.reg_wr = 1'b1; ctrl_s.mem_to_reg = M2R_CP0; end
                    I_MTC0:  ctrl_s.cp0_wr = 1'b1;
                    default: ctrl_s.reg_wr = 1'b0;
                endcase
                next_s = S_INT;
            end
            S_INT: begin
                if (take_s) begin
                    ctrl_s.pc_wr   = 1'b1;
                    ctrl_s.npc_sel = NPC_EXC;
                    ctrl_s.exl_set = 1'b1;
                    irq_id_sel_s   = irq_id_s;
                end else begin
                    ctrl_s.pc_wr   = 1'b0;
                end
                next_s = S_IF;
            end
            default: next_s = S_IF;
        endcase
    end

    // Reset silences every strobe immediately, including an in-flight memory request.
    assign ctrl_out_s     = rst ? '0 : ctrl_s;
    assign bus.pc_wr      = ctrl_out_s.pc_wr;
    assign bus.npc_sel    = ctrl_out_s.npc_sel;
    assign bus.reg_dst    = ctrl_out_s.reg_dst;
    assign bus.alu_src    = ctrl_out_s.alu_src;
    assign bus.alu_ctr    = ctrl_out_s.alu_ctr;
    assign bus.ext_op     = ctrl_out_s.ext_op;
    assign bus.mem_to_reg = ctrl_out_s.mem_to_reg;
    assign bus.reg_wr     = ctrl_out_s.reg_wr;
    assign bus.mem_req    = ctrl_out_s.mem_req;
    assign bus.mem_we     = ctrl_out_s.mem_we;
    assign bus.cp0_wr     = ctrl_out_s.cp0_wr;
    assign bus.mem_byte   = ctrl_out_s.mem_byte;
    assign bus.exl_set    = ctrl_out_s.exl_set;
    assign bus.exl_clr    = ctrl_out_s.exl_clr;
    assign bus.irq_id     = rst ? '0 : irq_id_sel_s;
    assign bus.state      = state_r;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign bus.exc_code   = rst ? 5'd0 : exc_code_s;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: per-instruction expected cycle traces from an ISA-level model.
module tb_mc_ctrl_fsm;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mc_ctrl_fsm_if #(.IRQ_W(6), .IRQ_ID_W(3)) bus ();
    mc_ctrl_fsm #(.IRQ_W(6), .IRQ_ID_W(3), .BRIDGE_HI(24'h7f)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [3:0] state;
        logic       pc_wr;
        logic [2:0] npc_sel;
        logic       reg_wr;
        logic [1:0] reg_dst;
        logic [2:0] mem_to_reg;
        logic       alu_src;
        logic [2:0] alu_ctr;
        logic [1:0] ext_op;
        logic       mem_req, mem_we, mem_byte, cp0_wr, exl_set, exl_clr;
        logic [2:0] irq_id;
    } obs_t;

    localparam int M_ADDU = 0, M_SUBU = 1, M_SLT = 2, M_JR = 3, M_JALR = 4, M_ADDI = 5, M_ADDIU = 6;
    localparam int M_ORI = 7, M_LUI = 8, M_LW = 9, M_SW = 10, M_LB = 11, M_SB = 12, M_BEQ = 13;
    localparam int M_BNE = 14, M_J = 15, M_JAL = 16, M_MFC0 = 17, M_MTC0 = 18, M_ERET = 19, M_BAD = 20;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    // MIPS32 encodings: opcode, funct, rs (funct/rs only meaningful where the ISA uses them)
    logic [5:0] op_tab [21] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0d, 6'h0f, 6'h23,
                                6'h2b, 6'h20, 6'h28, 6'h04, 6'h05, 6'h02, 6'h03, 6'h10, 6'h10, 6'h10, 6'h3f};
    logic [5:0] fn_tab [21] = '{6'h21, 6'h23, 6'h2a, 6'h08, 6'h09, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h18, 6'h00};
    logic [4:0] rs_tab [21] = '{5'h0, 5'h0, 5'h0, 5'h0, 5'h0, 5'h0, 5'h0, 5'h0, 5'h0, 5'h0,
                                5'h0, 5'h0, 5'h0, 5'h0, 5'h0, 5'h0, 5'h0, 5'h00, 5'h04, 5'h10, 5'h0};

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];
    logic ack_q[$];

    function automatic obs_t sample();
        obs_t o;
        o.state = bus.state;      o.pc_wr = bus.pc_wr;       o.npc_sel = bus.npc_sel;
        o.reg_wr = bus.reg_wr;    o.reg_dst = bus.reg_dst;   o.mem_to_reg = bus.mem_to_reg;
        o.alu_src = bus.alu_src;  o.alu_ctr = bus.alu_ctr;   o.ext_op = bus.ext_op;
        o.mem_req = bus.mem_req;  o.mem_we = bus.mem_we;     o.mem_byte = bus.mem_byte;
        o.cp0_wr = bus.cp0_wr;    o.exl_set = bus.exl_set;   o.exl_clr = bus.exl_clr;
        o.irq_id = bus.exl_set ? bus.irq_id : 3'd0;
        return o;
    endfunction

    function automatic obs_t with_alu(input obs_t o, input int k);
        obs_t r = o;
        case (k)
            M_SUBU:          r.alu_ctr = 3'd1;
            M_SLT:           r.alu_ctr = 3'd3;
            M_ADDI, M_ADDIU: begin r.alu_src = 1'b1; r.ext_op = 2'd1; end
            M_ORI:           begin r.alu_src = 1'b1; r.alu_ctr = 3'd2; end
            M_LUI:           begin r.alu_src = 1'b1; r.ext_op = 2'd2; end
            default:         r.alu_ctr = 3'd0;
        endcase
        return r;
    endfunction

    task automatic push(input obs_t o, input logic ack);
        exp_q.push_back(o);
        ack_q.push_back(ack);
    endtask

    // Reference model: expected per-cycle outputs for one whole instruction, IF through INT.
    task automatic build_trace(input int k, input int w, input logic z, input logic [5:0] pend,
                               input logic ie_v, input logic exl_v, input logic [31:0] addr);
        obs_t o;
        bit   is_mem   = (k == M_LW) || (k == M_SW) || (k == M_LB) || (k == M_SB);
        bit   is_store = (k == M_SW) || (k == M_SB);
        bit   is_jump  = (k == M_J) || (k == M_JAL) || (k == M_JR) || (k == M_JALR) || (k == M_ERET);
        bit   trapped  = TRAP && (k == M_BAD);
        exp_q.delete();
        ack_q.delete();
        o = '0; o.pc_wr = 1'b1;                          push(o, 1'($urandom));
        o = '0; o.state = 4'd1;
        if (k == M_J || k == M_JAL) begin o.pc_wr = 1'b1; o.npc_sel = 3'd2; end
        if (k == M_JR || k == M_JALR) begin o.pc_wr = 1'b1; o.npc_sel = 3'd3; end
        if (k == M_JAL || k == M_JALR) begin o.reg_wr = 1'b1; o.mem_to_reg = 3'd2; end
        if (k == M_JAL) o.reg_dst = 2'd2;
        if (k == M_JALR) o.reg_dst = 2'd1;
        if (k == M_ERET) begin o.pc_wr = 1'b1; o.npc_sel = 3'd4; o.exl_clr = 1'b1; end
        if (trapped) begin o.pc_wr = 1'b1; o.npc_sel = 3'd5; o.exl_set = 1'b1; end
        push(o, 1'($urandom));
        if (is_mem) begin
            o = '0; o.state = 4'd2; o.alu_src = 1'b1; o.ext_op = 2'd1; push(o, 1'($urandom));
            for (int j = 0; j <= w; j++) begin
                o = '0; o.state = 4'd3; o.mem_req = 1'b1; o.mem_we = is_store;
                o.mem_byte = (k == M_LB) || (k == M_SB);
                push(o, j == w);
            end
            if (!is_store) begin
                o = '0; o.state = 4'd4; o.reg_wr = 1'b1;
                o.mem_to_reg = (addr[31:8] == 24'h7f) ? 3'd4 : 3'd1;
                push(o, 1'($urandom));
            end
        end else if (k == M_BEQ || k == M_BNE) begin
            o = '0; o.state = 4'd5; o.alu_ctr = 3'd1;
            if ((k == M_BEQ) ? z : !z) begin o.pc_wr = 1'b1; o.npc_sel = 3'd1; end
            push(o, 1'($urandom));
        end else if (!is_jump && !trapped) begin
            o = '0; o.state = 4'd6; push(with_alu(o, k), 1'($urandom));
            o = '0; o.state = 4'd7; o = with_alu(o, k);
            if (k == M_ADDU || k == M_SUBU || k == M_SLT) begin o.reg_wr = 1'b1; o.reg_dst = 2'd1; end
            if (k == M_ADDI || k == M_ADDIU || k == M_ORI || k == M_LUI) o.reg_wr = 1'b1;
            if (k == M_MFC0) begin o.reg_wr = 1'b1; o.mem_to_reg = 3'd3; end
            if (k == M_MTC0) o.cp0_wr = 1'b1;
            push(o, 1'($urandom));
        end
        o = '0; o.state = 4'd8;
        if (pend != 6'd0 && ie_v && !exl_v) begin
            o.pc_wr = 1'b1; o.npc_sel = 3'd5; o.exl_set = 1'b1;
            for (int j = 5; j >= 0; j--) if (pend[j]) o.irq_id = 3'(j);
        end
        push(o, 1'($urandom));
    endtask

    // Drive one instruction's IR/status inputs and prepare its expected trace.
    task automatic apply(input int k, input int vsel, input int w, input logic z, input logic [5:0] irq_v,
                         input logic [5:0] mask_v, input logic ie_v, input logic exl_v,
                         input logic [31:0] addr);
        bus.op = op_tab[k];
        bus.funct = (k <= M_JALR || k == M_ERET) ? fn_tab[k] : 6'($urandom);
        bus.rs = (k >= M_MFC0 && k <= M_ERET) ? rs_tab[k] : 5'($urandom);
        if (k == M_BAD) begin
            if (vsel == 1) begin bus.op = 6'h00; bus.funct = 6'h3f; end
            if (vsel == 2) begin bus.op = 6'h10; bus.rs = 5'h1f; end
        end
        bus.zero = z; bus.irq = irq_v; bus.irq_mask = mask_v; bus.ie = ie_v; bus.exl = exl_v;
        bus.mem_addr = addr;
        build_trace(k, w, z, irq_v & mask_v, ie_v, exl_v, addr);
    endtask

    task automatic test_reset();
        obs_t got;
        rst = 1'b1;
        bus.op = 6'($urandom); bus.funct = 6'($urandom); bus.rs = 5'($urandom);
        bus.mem_addr = $urandom; bus.mem_ack = 1'b1; bus.zero = 1'b0;
        bus.irq = 6'h3f; bus.irq_mask = 6'h3f; bus.ie = 1'b1; bus.exl = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got = sample(); checks++;
            if (got !== obs_t'(0)) begin errors++; $display("FAIL reset cyc %0d: got %h expected 0", i, got); end
            checks++;
            if (bus.irq_id !== 3'd0) begin errors++; $display("FAIL reset_irq_id: got %0d expected 0", bus.irq_id); end
            @(posedge clk);
        end
        #1 rst = 1'b0;
    endtask

    task automatic test_addu();
        obs_t got;
        apply(M_ADDU, 0, 0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 32'h0);
        foreach (exp_q[i]) begin
            bus.mem_ack = ack_q[i]; @(negedge clk); got = sample(); checks++;
            if (got !== exp_q[i]) begin errors++; $display("FAIL addu cyc %0d: got %h expected %h", i, got, exp_q[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_wait();
        obs_t got;
        apply(M_LW, 0, 3, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 32'h0000_1004);
        foreach (exp_q[i]) begin
            bus.mem_ack = ack_q[i]; @(negedge clk); got = sample(); checks++;
            if (got !== exp_q[i]) begin errors++; $display("FAIL lw_wait cyc %0d: got %h expected %h", i, got, exp_q[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lb_bridge();
        obs_t got;
        apply(M_LB, 0, 1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 32'h7f00_0010);
        foreach (exp_q[i]) begin
            bus.mem_ack = ack_q[i]; @(negedge clk); got = sample(); checks++;
            if (got !== exp_q[i]) begin errors++; $display("FAIL lb_bridge cyc %0d: got %h expected %h", i, got, exp_q[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_bne();
        obs_t got;
        for (int zb = 0; zb < 2; zb++) begin
            apply(M_BNE, 0, 0, 1'(zb), 6'd0, 6'd0, 1'b0, 1'b0, 32'h0);
            foreach (exp_q[i]) begin
                bus.mem_ack = ack_q[i]; @(negedge clk); got = sample(); checks++;
                if (got !== exp_q[i]) begin errors++; $display("FAIL bne z=%0d cyc %0d: got %h expected %h", zb, i, got, exp_q[i]); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_irq();
        obs_t got;
        for (int e = 0; e < 2; e++) begin
            apply(M_ORI, 0, 0, 1'b0, 6'b001100, 6'b001000, 1'b1, 1'(e), 32'h0);
            foreach (exp_q[i]) begin
                bus.mem_ack = ack_q[i]; @(negedge clk); got = sample(); checks++;
                if (got !== exp_q[i]) begin errors++; $display("FAIL irq exl=%0d cyc %0d: got %h expected %h", e, i, got, exp_q[i]); end
                @(posedge clk); #1;
            end
            checks++;
            if (bus.state !== 4'd0) begin errors++; $display("FAIL irq_next_if: got state %0d expected 0", bus.state); end
        end
    endtask

    task automatic test_eret_irq();
        obs_t got;
        apply(M_ERET, 0, 0, 1'b0, 6'b110000, 6'b100000, 1'b1, 1'b0, 32'h0);
        foreach (exp_q[i]) begin
            bus.mem_ack = ack_q[i]; @(negedge clk); got = sample(); checks++;
            if (got !== exp_q[i]) begin errors++; $display("FAIL eret_irq cyc %0d: got %h expected %h", i, got, exp_q[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_unknown();
        obs_t got;
        for (int v = 0; v < 3; v++) begin
            apply(M_BAD, v, 0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 32'h0);
            foreach (exp_q[i]) begin
                bus.mem_ack = ack_q[i]; @(negedge clk); got = sample(); checks++;
                if (got !== exp_q[i]) begin errors++; $display("FAIL unknown v%0d cyc %0d: got %h expected %h", v, i, got, exp_q[i]); end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                if (i == 1) begin
                    checks++;
                    if (bus.exc_code !== 5'd10) begin errors++; $display("FAIL exc_code: got %0d expected 10", bus.exc_code); end
                end
`endif
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_rst_mid_mem();
        obs_t got;
        obs_t want;
        apply(M_SW, 0, 5, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 32'h0000_0200);
        for (int i = 0; i < 4; i++) begin
            bus.mem_ack = ack_q[i]; @(negedge clk); got = sample(); checks++;
            if (got !== exp_q[i]) begin errors++; $display("FAIL rst_mem pre cyc %0d: got %h expected %h", i, got, exp_q[i]); end
            @(posedge clk); #1;
        end
        rst = 1'b1; bus.mem_ack = 1'b0;
        @(negedge clk); got = sample(); want = '0; want.state = 4'd3; checks++;
        if (got !== want) begin errors++; $display("FAIL rst_mem drop: got %h expected %h", got, want); end
        @(posedge clk); #1;
        @(negedge clk); got = sample(); checks++;
        if (got !== obs_t'(0)) begin errors++; $display("FAIL rst_mem to_if: got %h expected 0", got); end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        obs_t got;
        for (int n = 0; n < 150; n++) begin
            int k = $urandom_range(0, 20);
            apply(k, $urandom_range(0, 2), $urandom_range(0, 4), 1'($urandom), 6'($urandom), 6'($urandom),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 1) == 1) ? {24'h7f, 8'($urandom)} : $urandom);
            foreach (exp_q[i]) begin
                bus.mem_ack = ack_q[i]; @(negedge clk); got = sample(); checks++;
                if (got !== exp_q[i]) begin errors++; $display("FAIL rand n%0d k%0d cyc %0d: got %h expected %h", n, k, i, got, exp_q[i]); end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_addu();
        test_lw_wait();
        test_lb_bridge();
        test_bne();
        test_irq();
        test_eret_irq();
        test_unknown();
        test_rst_mid_mem();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
